// File: rtl/alu_accum_pkg.sv
// -----------------------------------------------------------------------------
// alu_accum_pkg
// Purpose : Shared definitions for the add/subtract/accumulate core.
//           Holds the operation-mode enum, the mode field width and the
//           default operand/accumulator widths.
// Ports   : none (package)
// Config  : ALU_ACCUM_SAT_EN selects saturating arithmetic in the users of
//           this package; nothing here depends on it.
// -----------------------------------------------------------------------------
package alu_accum_pkg;

  localparam int MODE_W        = 2;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

endpackage

// File: rtl/alu_accum_if.sv
// -----------------------------------------------------------------------------
// alu_accum_if
// Purpose : Operand/result handshake bundle for alu_accum_core.
// Signals : in_valid/in_ready  - operand set handshake
//           op_a, op_b, mode   - operands and operation select
//           out_valid/out_ready- result handshake
//           result, flag       - registered result and carry/borrow/wrap flag
// Modports: master - the side presenting operands and consuming results
//           slave  - the arithmetic core
// Config  : ALU_ACCUM_SAT_EN has no effect on this interface.
// -----------------------------------------------------------------------------
interface alu_accum_if
  import alu_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  mode_e                mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] result;
  logic                 flag;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, result, flag
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, result, flag
  );

endinterface

// File: rtl/alu_accum_sat_add.sv
// -----------------------------------------------------------------------------
// alu_accum_sat_add
// Purpose : Combinational N-bit unsigned adder/subtractor. Returns the N-bit
//           sum (clamped when saturation is built in) and the carry-out
//           (add) or borrow (subtract).
// Ports   : i_a, i_b  - N-bit unsigned operands
//           i_sub     - 1 selects i_a - i_b, 0 selects i_a + i_b
//           o_sum     - N-bit result (modular, or clamped under saturation)
//           o_carry   - carry out of bit N-1 (add) / i_a < i_b (subtract)
// Config  : ALU_ACCUM_SAT_EN - when defined, o_sum clamps to all-ones on an
//           add overflow and to zero on a subtract borrow.
// -----------------------------------------------------------------------------
module alu_accum_sat_add #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic [N-1:0] o_sum,
  output logic         o_carry
);

  logic [N:0] w_full;

  // One extra bit: for an add it is the carry, for a subtract of
  // zero-extended operands it goes high exactly when i_a < i_b.
  assign w_full  = i_sub ? ({1'b0, i_a} - {1'b0, i_b})
                         : ({1'b0, i_a} + {1'b0, i_b});
  assign o_carry = w_full[N];

`ifdef ALU_ACCUM_SAT_EN
  assign o_sum = w_full[N] ? (i_sub ? '0 : '1) : w_full[N-1:0];
`else
  assign o_sum = w_full[N-1:0];
`endif

endmodule

// File: rtl/alu_accum_core.sv
// -----------------------------------------------------------------------------
// alu_accum_core
// Purpose : One-stage registered add/subtract/accumulate/load unit with
//           valid/ready handshakes on both sides and a persistent
//           accumulator register.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - alu_accum_if.slave (in_valid/in_ready, op_a, op_b,
//                    mode, out_valid/out_ready, result, flag)
// Params  : WIDTH (>= 2) operand width, ACC_WIDTH (>= WIDTH+1) accumulator
//           and result width.
// Config  : ALU_ACCUM_SAT_EN - saturating ADD/SUB/ACC; flag still reports the
//           carry/borrow that caused the clamp. Undefined: modular
//           arithmetic, ADD keeps its WIDTH+1-bit sum.
// -----------------------------------------------------------------------------
module alu_accum_core
  import alu_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_accum_if.slave bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("alu_accum_core: WIDTH must be >= 2");
  end
  if (ACC_WIDTH < WIDTH + 1) begin : g_bad_acc_width
    $error("alu_accum_core: ACC_WIDTH must be >= WIDTH+1");
  end

  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_result;
  logic                 r_flag;
  logic [ACC_WIDTH-1:0] r_acc;

  logic                 w_accept;
  logic                 w_is_sub;
  logic [ACC_WIDTH-1:0] w_op_a_ext;
  logic [WIDTH-1:0]     w_op_sum;
  logic                 w_op_carry;
  logic [ACC_WIDTH-1:0] w_acc_sum;
  logic                 w_acc_carry;
  logic [ACC_WIDTH-1:0] w_res_nxt;
  logic                 w_flag_nxt;
  logic [ACC_WIDTH-1:0] w_acc_nxt;

  // Ready only depends on the output register, never on in_valid, so no
  // combinational loop can form through an upstream that waits for ready.
  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  assign w_is_sub   = (bus.mode == MODE_SUB);
  assign w_op_a_ext = ACC_WIDTH'(bus.op_a);

  alu_accum_sat_add #(.N(WIDTH)) u_op_add (
    .i_a     (bus.op_a),
    .i_b     (bus.op_b),
    .i_sub   (w_is_sub),
    .o_sum   (w_op_sum),
    .o_carry (w_op_carry)
  );

  alu_accum_sat_add #(.N(ACC_WIDTH)) u_acc_add (
    .i_a     (r_acc),
    .i_b     (w_op_a_ext),
    .i_sub   (1'b0),
    .o_sum   (w_acc_sum),
    .o_carry (w_acc_carry)
  );

  always_comb begin
    w_res_nxt  = r_result;
    w_flag_nxt = r_flag;
    w_acc_nxt  = r_acc;
    case (bus.mode)
      MODE_ADD: begin
`ifdef ALU_ACCUM_SAT_EN
        w_res_nxt = ACC_WIDTH'(w_op_sum);
`else
        // Modular ADD keeps the carry as the top result bit.
        w_res_nxt = ACC_WIDTH'({w_op_carry, w_op_sum});
`endif
        w_flag_nxt = w_op_carry;
      end
      MODE_SUB: begin
        w_res_nxt  = ACC_WIDTH'(w_op_sum);
        w_flag_nxt = w_op_carry;
      end
      MODE_ACC: begin
        w_res_nxt  = w_acc_sum;
        w_acc_nxt  = w_acc_sum;
        w_flag_nxt = w_acc_carry;
      end
      MODE_LOAD: begin
        w_res_nxt  = w_op_a_ext;
        w_acc_nxt  = w_op_a_ext;
        w_flag_nxt = 1'b0;
      end
      default: begin
        w_res_nxt = r_result;
      end
    endcase
  end

  // Output stage: result/flag/acc only move on accept; a drain without a
  // new accept just drops out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flag      <= 1'b0;
      r_acc       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res_nxt;
      r_flag      <= w_flag_nxt;
      r_acc       <= w_acc_nxt;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flag      = r_flag;

endmodule

// File: tb/tb_alu_accum_core.sv
// -----------------------------------------------------------------------------
// tb_alu_accum_core
// Purpose : Self-checking bench for alu_accum_core. Two instances are built:
//           WIDTH=8/ACC_WIDTH=16 and WIDTH=8/ACC_WIDTH=9. Directed sequences
//           and randomized traffic are compared against an arithmetic
//           reference model kept in the bench.
// Config  : honours ALU_ACCUM_SAT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_accum_core;
  import alu_accum_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_accum_if #(.WIDTH(8), .ACC_WIDTH(16)) bus0 ();
  alu_accum_if #(.WIDTH(8), .ACC_WIDTH(9))  bus1 ();

  alu_accum_core #(.WIDTH(8), .ACC_WIDTH(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  alu_accum_core #(.WIDTH(8), .ACC_WIDTH(9)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state per instance.
  longint m_res  [2];
  longint m_acc  [2];
  bit     m_flag [2];
  bit     m_vld  [2];
  int     m_aw   [2] = '{16, 9};

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_res[d] = 0; m_acc[d] = 0; m_flag[d] = 0; m_vld[d] = 0;
    end
  endfunction

  // Arithmetic meaning of one accepted operation.
  function automatic void model_accept(input int d, input mode_e m, input longint a, input longint b);
    longint lim_w = longint'(1) << 8;
    longint lim_a = longint'(1) << m_aw[d];
    longint s;
    case (m)
      MODE_ADD: begin
        s = a + b;
        m_flag[d] = (s >= lim_w);
`ifdef ALU_ACCUM_SAT_EN
        m_res[d] = m_flag[d] ? lim_w - 1 : s;
`else
        m_res[d] = s;
`endif
      end
      MODE_SUB: begin
        m_flag[d] = (a < b);
`ifdef ALU_ACCUM_SAT_EN
        m_res[d] = m_flag[d] ? 0 : a - b;
`else
        m_res[d] = (a - b + lim_w) % lim_w;
`endif
      end
      MODE_ACC: begin
        s = m_acc[d] + a;
        m_flag[d] = (s >= lim_a);
`ifdef ALU_ACCUM_SAT_EN
        m_acc[d] = m_flag[d] ? lim_a - 1 : s;
`else
        m_acc[d] = s % lim_a;
`endif
        m_res[d] = m_acc[d];
      end
      default: begin
        m_res[d] = a; m_acc[d] = a; m_flag[d] = 0;
      end
    endcase
    m_vld[d] = 1;
  endfunction

  task automatic drive(input int d, input bit v, input mode_e m,
                       input logic [7:0] a, input logic [7:0] b, input bit ordy);
    if (d == 0) begin
      bus0.in_valid = v; bus0.mode = m; bus0.op_a = a; bus0.op_b = b; bus0.out_ready = ordy;
    end else begin
      bus1.in_valid = v; bus1.mode = m; bus1.op_a = a; bus1.op_b = b; bus1.out_ready = ordy;
    end
  endtask

  function automatic logic [63:0] obs_rdy(input int d);
    return (d == 0) ? 64'(bus0.in_ready) : 64'(bus1.in_ready);
  endfunction
  function automatic logic [63:0] obs_vld(input int d);
    return (d == 0) ? 64'(bus0.out_valid) : 64'(bus1.out_valid);
  endfunction
  function automatic logic [63:0] obs_res(input int d);
    return (d == 0) ? 64'(bus0.result) : 64'(bus1.result);
  endfunction
  function automatic logic [63:0] obs_flag(input int d);
    return (d == 0) ? 64'(bus0.flag) : 64'(bus1.flag);
  endfunction

  // One clock on instance d; the other instance is frozen (no valid, no ready).
  task automatic step(input int d, input bit v, input mode_e m, input int a, input int b,
                      input bit ordy, input string tag);
    bit exp_rdy;
    logic [7:0] a8, b8;
    a8 = a[7:0];
    b8 = b[7:0];
    @(negedge clk);
    drive(d, v, m, a8, b8, ordy);
    drive(1 - d, 1'b0, MODE_ADD, 8'h00, 8'h00, 1'b0);
    #1;
    exp_rdy = !m_vld[d] || ordy;
    chk_eq({tag, ".in_ready"}, obs_rdy(d), 64'(exp_rdy));
    @(posedge clk);
    if (v && exp_rdy) model_accept(d, m, longint'(a8), longint'(b8));
    else if (m_vld[d] && ordy) m_vld[d] = 0;
    #1;
    chk_eq({tag, ".out_valid"}, obs_vld(d), 64'(m_vld[d]));
    chk_eq({tag, ".result"}, obs_res(d), 64'(m_res[d]));
    chk_eq({tag, ".flag"}, obs_flag(d), 64'(m_flag[d]));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, MODE_ADD, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, MODE_ADD, 8'h00, 8'h00, 1'b0);
    model_reset();
    #22;
    chk_eq("rst.out_valid", obs_vld(0), 64'd0);
    chk_eq("rst.result", obs_res(0), 64'd0);
    chk_eq("rst.flag", obs_flag(0), 64'd0);
    chk_eq("rst.in_ready", obs_rdy(0), 64'd1);
    chk_eq("rst1.result", obs_res(1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- 16-bit accumulator instance: directed ----
    step(0, 1, MODE_ADD, 200, 100, 1, "add");
`ifdef ALU_ACCUM_SAT_EN
    chk_eq("add.lit", obs_res(0), 64'h00FF);
`else
    chk_eq("add.lit", obs_res(0), 64'h012C);
`endif
    chk_eq("add.litflag", obs_flag(0), 64'd1);

    step(0, 1, MODE_SUB, 5, 7, 1, "sub");
`ifdef ALU_ACCUM_SAT_EN
    chk_eq("sub.lit", obs_res(0), 64'h0000);
`else
    chk_eq("sub.lit", obs_res(0), 64'h00FE);
`endif
    chk_eq("sub.litflag", obs_flag(0), 64'd1);

    step(0, 1, MODE_LOAD, 'h10, 0, 1, "load");
    chk_eq("load.lit", obs_res(0), 64'h0010);
    step(0, 1, MODE_ACC, 'h20, 0, 1, "acc1");
    chk_eq("acc1.lit", obs_res(0), 64'h0030);
    step(0, 1, MODE_ACC, 'h30, 0, 1, "acc2");
    chk_eq("acc2.lit", obs_res(0), 64'h0060);
    chk_eq("acc2.litflag", obs_flag(0), 64'd0);

    // Backpressure: hold three cycles with a new ACC pending.
    step(0, 1, MODE_ACC, 'h01, 0, 1, "bp.acc");
    for (int i = 0; i < 3; i++) step(0, 1, MODE_ACC, 'h05, 0, 0, "bp.stall");
    chk_eq("bp.held", obs_res(0), 64'h0061);
    step(0, 1, MODE_ACC, 'h05, 0, 1, "bp.release");
    chk_eq("bp.lit", obs_res(0), 64'h0066);

    // Reset pulse while a result is held under stall.
    step(0, 1, MODE_ACC, 'h02, 0, 1, "rs.acc");
    step(0, 0, MODE_ACC, 0, 0, 0, "rs.stall");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_eq("rs.out_valid", obs_vld(0), 64'd0);
    chk_eq("rs.result", obs_res(0), 64'd0);
    chk_eq("rs.in_ready", obs_rdy(0), 64'd1);
    #1;
    rst_n = 1'b1;
    step(0, 1, MODE_ACC, 'h07, 0, 1, "rs.acc7");
    chk_eq("rs.lit", obs_res(0), 64'h0007);

    // ---- 9-bit accumulator instance: wrap / saturate ----
    step(1, 1, MODE_LOAD, 'hF0, 0, 1, "w9.load");
    step(1, 1, MODE_ACC, 'hFF, 0, 1, "w9.acc1");
    step(1, 1, MODE_ACC, 'hFF, 0, 1, "w9.acc2");
    step(1, 1, MODE_LOAD, 'hFF, 0, 1, "w9.load2");
    step(1, 1, MODE_ACC, 'hFF, 0, 1, "w9.acc3");
    chk_eq("w9.mid", obs_res(1), 64'h01FE);
    step(1, 1, MODE_ACC, 'hFF, 0, 1, "w9.acc4");
`ifdef ALU_ACCUM_SAT_EN
    chk_eq("w9.lit", obs_res(1), 64'h01FF);
`else
    chk_eq("w9.lit", obs_res(1), 64'h00FD);
`endif
    chk_eq("w9.litflag", obs_flag(1), 64'd1);
    step(1, 1, MODE_ADD, 255, 255, 1, "w9.add");

    // ---- randomized traffic on both instances ----
    for (int i = 0; i < 600; i++) begin
      step(i % 2, ($urandom_range(0, 3) != 0), mode_e'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 7), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
